// File: rtl/data_bus_responder_if.sv
// Load/store port between the single-cycle datapath and its data bus.
// The responder side uses the memory modport.
interface data_memory_if;
    logic [31:0] addr;
    logic [31:0] write_data;
    logic        write_enable;
    logic [31:0] read_data;

    modport memory (
        input  addr,
        input  write_data,
        input  write_enable,
        output read_data
    );

    modport datapath (
        output addr,
        output write_data,
        output write_enable,
        input  read_data
    );
endinterface

// File: rtl/data_bus_responder.sv
// Data bus responder: word RAM, free-running CYCLE counter and console TX FIFO.
// Console FIFO, CONSOLE_TX and STATUS exist only when DATA_BUS_CONSOLE_EN is defined.
module data_bus_responder #(
    parameter int RamWords  = 256,
    parameter int FifoDepth = 8
) (
    input  logic          clk,
    input  logic          rst,
    data_memory_if.memory data_mem_if,
    output logic [7:0]    console_data,
    output logic          console_valid,
    input  logic          console_ready
);

    localparam int AW = $clog2(RamWords);
    localparam int CW = $clog2(FifoDepth);

    localparam logic [29:0] CycleWord  = 30'h2000_0000;
`ifdef DATA_BUS_CONSOLE_EN
    localparam logic [29:0] TxWord     = 30'h2000_0001;
    localparam logic [29:0] StatusWord = 30'h2000_0002;
`endif

    logic [31:0]   addr;
    logic [31:0]   wdata;
    logic          we;
    logic [29:0]   word_addr;
    logic [AW-1:0] ram_idx;
    logic [31:0]   rdata;
    logic          unused_addr;

    assign addr        = data_mem_if.addr;
    assign wdata       = data_mem_if.write_data;
    assign we          = data_mem_if.write_enable;
    assign word_addr   = addr[31:2];
    assign ram_idx     = addr[AW+1:2];
    assign unused_addr = ^addr[1:0];

    logic sel_ram;
    logic sel_cycle;

    // Decode the word address into the mapped regions
    always_comb begin
        sel_ram   = (addr[31:AW+2] == '0);
        sel_cycle = (word_addr == CycleWord);
    end

    logic [31:0] cycle_q;
    logic [31:0] cycle_d;

    // CYCLE advances every cycle unless the datapath loads it
    always_comb begin
        cycle_d = cycle_q + 32'd1;
        if (we && sel_cycle) begin
            cycle_d = wdata;
        end
    end

    // CYCLE register
    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_q <= '0;
        end else begin
            cycle_q <= cycle_d;
        end
    end

    logic [31:0] ram_q [RamWords];

    // Word RAM write port; contents survive reset
    always_ff @(posedge clk) begin
        if (we && sel_ram) begin
            ram_q[ram_idx] <= wdata;
        end
    end

`ifdef DATA_BUS_CONSOLE_EN
    logic          sel_tx;
    logic          sel_status;
    logic [7:0]    fifo_q [FifoDepth];
    logic [CW-1:0] wr_ptr_q;
    logic [CW-1:0] wr_ptr_d;
    logic [CW-1:0] rd_ptr_q;
    logic [CW-1:0] rd_ptr_d;
    logic [CW:0]   count_q;
    logic [CW:0]   count_d;
    logic          ovf_q;
    logic          ovf_d;
    logic          empty;
    logic          full;
    logic          push_req;
    logic          push;
    logic          pop;
    logic          drop;
    logic [31:0]   status_word;

    // Console register decode
    always_comb begin
        sel_tx     = (word_addr == TxWord);
        sel_status = (word_addr == StatusWord);
    end

    // FIFO next state; a pop in the same cycle frees room for a push when full
    always_comb begin
        empty    = (count_q == '0);
        full     = (count_q == (CW+1)'(FifoDepth));
        pop      = !empty && console_ready;
        push_req = we && sel_tx;
        push     = push_req && (!full || pop);
        drop     = push_req && full && !pop;
        wr_ptr_d = push ? wr_ptr_q + CW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + CW'(1) : rd_ptr_q;
        count_d  = count_q + (CW+1)'(push) - (CW+1)'(pop);
        ovf_d    = ovf_q;
        if (we && sel_status) begin
            ovf_d = 1'b0;
        end else if (drop) begin
            ovf_d = 1'b1;
        end
    end

    // FIFO control registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    // FIFO byte storage; reset discards the push
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            fifo_q[wr_ptr_q] <= wdata[7:0];
        end
    end

    // Stream head and STATUS view depend on FIFO state only
    always_comb begin
        console_valid = !empty;
        console_data  = empty ? 8'h00 : fifo_q[rd_ptr_q];
        status_word   = 32'({count_q, 5'b0, ovf_q, full, empty});
    end
`else
    logic unused_console;

    assign unused_console = console_ready;
    assign console_valid  = 1'b0;
    assign console_data   = 8'h00;
`endif

    // Combinational read mux; unmapped addresses read zero
    always_comb begin
        rdata = '0;
        if (sel_ram) begin
            rdata = ram_q[ram_idx];
        end else if (sel_cycle) begin
            rdata = cycle_q;
`ifdef DATA_BUS_CONSOLE_EN
        end else if (sel_status) begin
            rdata = status_word;
`endif
        end
    end

    assign data_mem_if.read_data = rdata;

endmodule
